fp_div_norm_round: RTL and testbench
====================================

Name: fp_div_norm_round

Overview:
Post-processing stage of the 32-bit FP divider, directly downstream of the mantissa divider. It takes the raw 27-bit quotient, remainder-nonzero flag, pre-computed sign/exponent and special-case flags. It normalizes, handles subnormals, rounds per RISC-V frm, and packs an IEEE-754 single result plus fflags. The block is a 2-stage valid/ready pipeline that feeds the FP unit writeback.

Parameters:
EXP_W, 10, width of signed pre-normalization biased exponent input
Q_W, 27, quotient width (bit Q_W-1 weight 2^0, remaining bits fraction)

Ports:
in_Clk  input  1  clock
in_Rst  input  1  reset; one clock; reset is synchronous and active-high
in_valid  input  1  upstream operand valid
out_in_ready  output  1  block can accept operand this cycle
in_sign  input  1  result sign (sa ^ sb)
in_exp  input  EXP_W  signed biased exponent ea - eb + 127
in_quot  input  Q_W  mantissa quotient, range (0.5, 2)
in_rem_nz  input  1  final remainder nonzero (sticky)
in_rm  input  3  frm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
in_is_nan  input  1  result is NaN
in_invalid  input  1  invalid op (0/0, inf/inf, sNaN operand)
in_div_zero  input  1  finite nonzero / 0
in_is_inf  input  1  result is inf (inf/finite)
in_is_zero  input  1  result is zero (0/x, finite/inf)
out_valid  output  1  result valid
in_ready  input  1  downstream accepts result
out_result  output  32  packed single-precision result
out_fflags  output  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Reset: s1_valid = s2_valid = 0; out_valid = 0; out_result = 0; out_fflags = 0. A reset mid-operation discards all in-flight operands.
- Handshake: transfer in on in_valid & out_in_ready; transfer out on out_valid & in_ready.
- Pipeline advance: s2 loads when !s2_valid | in_ready. s1 advances when s1_valid and s2 loads. out_in_ready = !s1_valid | s1 advances (combinational). Latency is 2 cycles with no stall; throughput is 1 per cycle.
- While out_valid & !in_ready, out_result and out_fflags hold stable.
- Stage 1, normalize:
  - If quot[26] = 1: M = quot[26:3], G = quot[2], S = quot[1] | quot[0] | rem_nz, E = in_exp.
  - Else: M = quot[25:2], G = quot[1], S = quot[0] | rem_nz, E = in_exp - 1.
- Stage 1, subnormal: if E <= 0, shift {M,G} right by sh = 1 - E, saturated at 26. Bits shifted out OR into S. Set E_biased = 0.
- Stage 1 registers M (24 bits), G, S, E (EXP_W), sign, rm, special flags, tiny = (E <= 0).
- Stage 2, round increment:
  - RNE: G & (S | M[0])
  - RTZ: 0
  - RDN: sign & (G | S)
  - RUP: !sign & (G | S)
  - RMM: G
  - Reserved rm values behave as RNE.
- Stage 2, result assembly:
  - Mr = M + inc (25 bits). If Mr[24] = 1, increment E and take Mr[24:1]; this includes subnormal-to-normal carry (E 0 -> 1).
  - NX = G | S. UF = tiny & NX.
- Overflow: if E >= 255 after rounding, OF = NX = 1. Result is inf when rm ∈ {RNE, RMM}, or RUP & !sign, or RDN & sign. Otherwise result is max finite 0x7F7FFFFF with the sign bit.
- Specials bypass arithmetic but take the same 2-cycle latency. Priority is NaN > div_zero > inf > zero > normal.
  - NaN: 0x7FC00000, NV = in_invalid, other flags 0.
  - div_zero: signed inf, DZ = 1.
  - inf: signed inf, flags 0.
  - zero: signed zero, flags 0.
- Pack: {sign, E[7:0], Mr[22:0]}. E field is 0 when the result is subnormal or zero.

Test Plan:
- 6.0/2.0: in_exp = 128, quot = 0x6000000, rem_nz = 0, RNE -> out_result 0x40400000, fflags 0x00, 2 cycles after accept.
- 1.0/1.5: in_exp = 127, quot = 0x2AAAAAA, rem_nz = 1.
  - RNE -> 0x3F2AAAAB, fflags 0x01.
  - RTZ -> 0x3F2AAAAA, fflags 0x01.
- Overflow: in_exp = 300, quot = 0x4000000, sign = 0.
  - RNE -> 0x7F800000, fflags 0x05.
  - RTZ -> 0x7F7FFFFF, fflags 0x05.
- Subnormal: in_exp = -2, quot = 0x4000000, rem_nz = 0 -> 0x00100000, fflags 0x00. Same with rem_nz = 1, RUP -> 0x00100001, fflags 0x03.
- Specials:
  - in_is_nan & in_invalid -> 0x7FC00000, fflags 0x10.
  - in_div_zero, sign = 1 -> 0xFF800000, fflags 0x08.
- Backpressure/reset: issue 3 back-to-back ops with in_ready held low.
  - out_in_ready drops after 2 accepts; outputs stay stable; all 3 results emerge in order once in_ready rises.
  - Asserting in_Rst mid-stream clears out_valid the next cycle.

Source files
------------

// File: rtl/fp_div_norm_round.sv
// rtl/fp_div_norm_round.sv - normalize, subnormal-shift, round and pack stage of the FP32 divider
module fp_div_norm_round #(
   parameter int EXP_W = 10,
   parameter int Q_W   = 27
) (
   input  logic             in_Clk,
   input  logic             in_Rst,
   input  logic             in_valid,
   output logic             out_in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [Q_W-1:0]   in_quot,
   input  logic             in_rem_nz,
   input  logic [2:0]       in_rm,
   input  logic             in_is_nan,
   input  logic             in_invalid,
   input  logic             in_div_zero,
   input  logic             in_is_inf,
   input  logic             in_is_zero,
   output logic             out_valid,
   input  logic             in_ready,
   output logic [31:0]      out_result,
   output logic [4:0]       out_fflags
);

   localparam logic [2:0]     RM_RNE = 3'b000;
   localparam logic [2:0]     RM_RTZ = 3'b001;
   localparam logic [2:0]     RM_RDN = 3'b010;
   localparam logic [2:0]     RM_RUP = 3'b011;
   localparam logic [2:0]     RM_RMM = 3'b100;
   localparam logic [EXP_W:0] E_ONE  = (EXP_W+1)'(1);
   localparam logic [EXP_W:0] SH_MAX = (EXP_W+1)'(26);
   localparam logic [EXP_W:0] E_MAX  = (EXP_W+1)'(255);

   logic             s1_valid_q, s1_valid_d;
   logic             s1_sign_q, s1_sign_d;
   logic [23:0]      s1_m_q, s1_m_d;
   logic             s1_g_q, s1_g_d;
   logic             s1_s_q, s1_s_d;
   logic [EXP_W-1:0] s1_e_q, s1_e_d;
   logic             s1_tiny_q, s1_tiny_d;
   logic [2:0]       s1_rm_q, s1_rm_d;
   logic             s1_nan_q, s1_nan_d;
   logic             s1_inv_q, s1_inv_d;
   logic             s1_dz_q, s1_dz_d;
   logic             s1_inf_q, s1_inf_d;
   logic             s1_zero_q, s1_zero_d;

   logic             s2_valid_q, s2_valid_d;
   logic [31:0]      s2_result_q, s2_result_d;
   logic [4:0]       s2_fflags_q, s2_fflags_d;

   logic             s2_load, s1_adv, accept;

   logic [EXP_W:0]   exp_sx, e_norm, sh_raw;
   logic [23:0]      m_n;
   logic             g_n, s_n, tiny_n;
   logic [4:0]       sh;
   logic [50:0]      sh_vec;
   logic [2:0]       rm_n;

   logic             inc, nx, ovf, ovf_inf;
   logic [24:0]      mr;
   logic [EXP_W:0]   e_r;
   logic [22:0]      frac;
   logic [31:0]      res_n;
   logic [4:0]       fl_n;

   always_comb begin
      s2_load      = !s2_valid_q || in_ready;
      s1_adv       = s1_valid_q && s2_load;
      out_in_ready = !s1_valid_q || s1_adv;
      accept       = in_valid && out_in_ready;
   end

   // Stage 1: put the leading one at M[23], then denormalize when the exponent underflows.
   always_comb begin
      exp_sx = {in_exp[EXP_W-1], in_exp};
      if (in_quot[Q_W-1]) begin
         m_n    = in_quot[Q_W-1 -: 24];
         g_n    = in_quot[Q_W-25];
         s_n    = (|in_quot[Q_W-26:0]) | in_rem_nz;
         e_norm = exp_sx;
      end else begin
         m_n    = in_quot[Q_W-2 -: 24];
         g_n    = in_quot[Q_W-26];
         s_n    = (|in_quot[Q_W-27:0]) | in_rem_nz;
         e_norm = exp_sx - E_ONE;
      end
      tiny_n = e_norm[EXP_W] || (e_norm == '0);
      sh_raw = E_ONE - e_norm;
      sh     = (sh_raw > SH_MAX) ? 5'd26 : sh_raw[4:0];
      sh_vec = {m_n, g_n, 26'b0} >> sh;
      rm_n   = (in_rm > RM_RMM) ? RM_RNE : in_rm;
   end

   always_comb begin
      s1_valid_d = out_in_ready ? in_valid : s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_m_d     = s1_m_q;
      s1_g_d     = s1_g_q;
      s1_s_d     = s1_s_q;
      s1_e_d     = s1_e_q;
      s1_tiny_d  = s1_tiny_q;
      s1_rm_d    = s1_rm_q;
      s1_nan_d   = s1_nan_q;
      s1_inv_d   = s1_inv_q;
      s1_dz_d    = s1_dz_q;
      s1_inf_d   = s1_inf_q;
      s1_zero_d  = s1_zero_q;
      if (accept) begin
         s1_sign_d = in_sign;
         s1_tiny_d = tiny_n;
         s1_rm_d   = rm_n;
         s1_nan_d  = in_is_nan;
         s1_inv_d  = in_invalid;
         s1_dz_d   = in_div_zero;
         s1_inf_d  = in_is_inf;
         s1_zero_d = in_is_zero;
         if (tiny_n) begin
            s1_m_d = sh_vec[50:27];
            s1_g_d = sh_vec[26];
            s1_s_d = s_n | (|sh_vec[25:0]);
            s1_e_d = '0;
         end else begin
            s1_m_d = m_n;
            s1_g_d = g_n;
            s1_s_d = s_n;
            s1_e_d = e_norm[EXP_W-1:0];
         end
      end
   end

   always_comb begin
      case (s1_rm_q)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = s1_sign_q & (s1_g_q | s1_s_q);
         RM_RUP:  inc = !s1_sign_q & (s1_g_q | s1_s_q);
         RM_RMM:  inc = s1_g_q;
         default: inc = s1_g_q & (s1_s_q | s1_m_q[0]);
      endcase
      mr = {1'b0, s1_m_q} + {24'b0, inc};
      // A subnormal that rounds up into M[23] becomes the smallest normal.
      if (s1_tiny_q)
         e_r = {{EXP_W{1'b0}}, mr[23]};
      else
         e_r = {1'b0, s1_e_q} + {{EXP_W{1'b0}}, mr[24]};
      frac    = mr[24] ? mr[23:1] : mr[22:0];
      nx      = s1_g_q | s1_s_q;
      ovf     = (e_r >= E_MAX);
      ovf_inf = (s1_rm_q == RM_RNE) || (s1_rm_q == RM_RMM) ||
                ((s1_rm_q == RM_RUP) && !s1_sign_q) ||
                ((s1_rm_q == RM_RDN) && s1_sign_q);

      if (s1_nan_q) begin
         res_n = 32'h7FC0_0000;
         fl_n  = {s1_inv_q, 4'b0000};
      end else if (s1_dz_q) begin
         res_n = {s1_sign_q, 31'h7F80_0000};
         fl_n  = 5'b01000;
      end else if (s1_inf_q) begin
         res_n = {s1_sign_q, 31'h7F80_0000};
         fl_n  = 5'b00000;
      end else if (s1_zero_q) begin
         res_n = {s1_sign_q, 31'h0};
         fl_n  = 5'b00000;
      end else if (ovf) begin
         res_n = {s1_sign_q, ovf_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
         fl_n  = 5'b00101;
      end else begin
         res_n = {s1_sign_q, e_r[7:0], frac};
         fl_n  = {3'b000, s1_tiny_q & nx, nx};
      end
   end

   always_comb begin
      s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
      s2_result_d = s2_result_q;
      s2_fflags_d = s2_fflags_q;
      if (s1_adv) begin
         s2_result_d = res_n;
         s2_fflags_d = fl_n;
      end
   end

   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_m_q      <= '0;
         s1_g_q      <= 1'b0;
         s1_s_q      <= 1'b0;
         s1_e_q      <= '0;
         s1_tiny_q   <= 1'b0;
         s1_rm_q     <= '0;
         s1_nan_q    <= 1'b0;
         s1_inv_q    <= 1'b0;
         s1_dz_q     <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_zero_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_fflags_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_m_q      <= s1_m_d;
         s1_g_q      <= s1_g_d;
         s1_s_q      <= s1_s_d;
         s1_e_q      <= s1_e_d;
         s1_tiny_q   <= s1_tiny_d;
         s1_rm_q     <= s1_rm_d;
         s1_nan_q    <= s1_nan_d;
         s1_inv_q    <= s1_inv_d;
         s1_dz_q     <= s1_dz_d;
         s1_inf_q    <= s1_inf_d;
         s1_zero_q   <= s1_zero_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_fflags_q <= s2_fflags_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_fflags = s2_fflags_q;

endmodule

// File: tb/tb_fp_div_norm_round.sv
// tb/tb_fp_div_norm_round.sv - self-checking bench for fp_div_norm_round
module tb_fp_div_norm_round;

   logic        in_Clk = 1'b0;
   logic        in_Rst;
   logic        in_valid;
   logic        out_in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [26:0] in_quot;
   logic        in_rem_nz;
   logic [2:0]  in_rm;
   logic        in_is_nan, in_invalid, in_div_zero, in_is_inf, in_is_zero;
   logic        out_valid;
   logic        in_ready;
   logic [31:0] out_result;
   logic [4:0]  out_fflags;

   always #5 in_Clk = ~in_Clk;

   fp_div_norm_round #(.EXP_W(10), .Q_W(27)) dut (
      .in_Clk       (in_Clk),
      .in_Rst       (in_Rst),
      .in_valid     (in_valid),
      .out_in_ready (out_in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_quot      (in_quot),
      .in_rem_nz    (in_rem_nz),
      .in_rm        (in_rm),
      .in_is_nan    (in_is_nan),
      .in_invalid   (in_invalid),
      .in_div_zero  (in_div_zero),
      .in_is_inf    (in_is_inf),
      .in_is_zero   (in_is_zero),
      .out_valid    (out_valid),
      .in_ready     (in_ready),
      .out_result   (out_result),
      .out_fflags   (out_fflags)
   );

   typedef struct {
      logic        sign;
      int          ex;
      logic [26:0] quot;
      logic        rem_nz;
      logic [2:0]  rm;
      logic        nan, inv, dz, inf, zero;
      logic [31:0] res;
      logic [4:0]  fl;
   } vec_t;

   vec_t        vecs[$];
   logic [36:0] exp_q[$];
   int          passed = 0;
   int          total  = 0;
   logic        acc_last;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, req);
   endtask

   function automatic vec_t mk(input logic sg, input int ex, input logic [26:0] q, input logic rnz,
                               input logic [2:0] rm, input logic [4:0] sp, input logic [31:0] res,
                               input logic [4:0] fl);
      vec_t v;
      v.sign = sg; v.ex = ex; v.quot = q; v.rem_nz = rnz; v.rm = rm;
      {v.nan, v.inv, v.dz, v.inf, v.zero} = sp;
      v.res = res; v.fl = fl;
      return v;
   endfunction

   // Reference: scale the quotient into units of the destination ulp and round that integer.
   function automatic logic [36:0] ref_model(input logic sgn, input int ex, input logic [26:0] q,
         input logic rnz, input logic [2:0] rm, input logic nan, input logic inv,
         input logic dz, input logic inf, input logic zr);
      int msb, e, s;
      longint qv, qq, rem, half, mag, enc;
      logic above, tie, nx, up, tiny, to_inf;
      logic [63:0] encv;
      if (nan) return {inv, 4'b0000, 32'h7FC00000};
      if (dz)  return {5'b01000, sgn, 31'h7F800000};
      if (inf) return {5'b00000, sgn, 31'h7F800000};
      if (zr)  return {5'b00000, sgn, 31'h0};
      msb = 0;
      for (int i = 0; i < 27; i++) if (q[i]) msb = i;
      e    = ex - (26 - msb);
      tiny = (e <= 0);
      s    = (tiny ? 1 : e) - 150 - (ex - 153);
      qv   = longint'(q);
      if (s > 40) begin
         qq = 0; above = 1'b0; tie = 1'b0; nx = 1'b1;
      end else begin
         qq    = qv >>> s;
         rem   = qv - (qq << s);
         half  = longint'(1) << (s - 1);
         above = (rem > half) || (rem == half && rnz);
         tie   = (rem == half) && !rnz;
         nx    = (rem != 0) || rnz;
      end
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = sgn && nx;
         3'd3:    up = !sgn && nx;
         3'd4:    up = above || tie;
         default: up = above || (tie && (qq % 2 == 1));
      endcase
      mag = qq + (up ? 1 : 0);
      enc = tiny ? mag : (longint'(e - 1) << 23) + mag;
      if (enc >= longint'(32'h7F800000)) begin
         to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sgn : (rm == 3'd3) ? !sgn : 1'b1;
         return {5'b00101, sgn, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
      end
      encv = enc;
      return {3'b000, tiny && nx, nx, sgn, encv[30:0]};
   endfunction

   task automatic apply_vec(input vec_t v);
      in_sign = v.sign; in_exp = 10'(v.ex); in_quot = v.quot; in_rem_nz = v.rem_nz; in_rm = v.rm;
      in_is_nan = v.nan; in_invalid = v.inv; in_div_zero = v.dz; in_is_inf = v.inf; in_is_zero = v.zero;
   endtask

   task automatic rand_inputs();
      int ex, sp, reg_sel;
      reg_sel = $urandom_range(0, 2);
      if (reg_sel == 0)      ex = int'($urandom_range(0, 35)) - 30;
      else if (reg_sel == 1) ex = int'($urandom_range(248, 260));
      else                   ex = int'($urandom_range(0, 360)) - 60;
      sp = $urandom_range(0, 15);
      in_sign     = 1'($urandom_range(0, 1));
      in_exp      = 10'(ex);
      in_quot     = 27'($urandom_range(32'h2000001, 32'h7FFFFFF));
      in_rem_nz   = 1'($urandom_range(0, 1));
      in_rm       = 3'($urandom_range(0, 7));
      in_is_nan   = (sp == 0);
      in_invalid  = 1'($urandom_range(0, 1));
      in_div_zero = (sp == 1) || (sp == 4);
      in_is_inf   = (sp == 2) || (sp == 4);
      in_is_zero  = (sp == 3) || (sp == 2);
   endtask

   // One clock: sample handshakes away from the edge, score them, then advance.
   task automatic step();
      logic [36:0] e;
      #1;
      acc_last = in_valid && out_in_ready;
      if (acc_last)
         exp_q.push_back(ref_model(in_sign, int'($signed(in_exp)), in_quot, in_rem_nz, in_rm,
                                   in_is_nan, in_invalid, in_div_zero, in_is_inf, in_is_zero));
      if (out_valid && in_ready) begin
         if (exp_q.size() == 0) chk("stream_extra", 64'(out_valid), 64'(0));
         else begin
            e = exp_q.pop_front();
            chk("stream", {out_fflags, out_result}, 64'(e));
         end
      end
      @(posedge in_Clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, idx, sent, cyc;
      logic [36:0] hold_r;

      vecs.push_back(mk(0, 128, 27'h6000000, 0, 3'd0, 5'b00000, 32'h40400000, 5'h00));
      vecs.push_back(mk(0, 127, 27'h2AAAAAA, 1, 3'd0, 5'b00000, 32'h3F2AAAAB, 5'h01));
      vecs.push_back(mk(0, 127, 27'h2AAAAAA, 1, 3'd1, 5'b00000, 32'h3F2AAAAA, 5'h01));
      vecs.push_back(mk(0, 300, 27'h4000000, 0, 3'd0, 5'b00000, 32'h7F800000, 5'h05));
      vecs.push_back(mk(0, 300, 27'h4000000, 0, 3'd1, 5'b00000, 32'h7F7FFFFF, 5'h05));
      vecs.push_back(mk(0,  -2, 27'h4000000, 0, 3'd0, 5'b00000, 32'h00100000, 5'h00));
      vecs.push_back(mk(0,  -2, 27'h4000000, 1, 3'd3, 5'b00000, 32'h00100001, 5'h03));
      vecs.push_back(mk(0, 127, 27'h4000000, 0, 3'd0, 5'b11000, 32'h7FC00000, 5'h10));
      vecs.push_back(mk(1, 127, 27'h4000000, 0, 3'd0, 5'b00100, 32'hFF800000, 5'h08));
      vecs.push_back(mk(1, 300, 27'h4000000, 0, 3'd2, 5'b00000, 32'hFF800000, 5'h05));
      vecs.push_back(mk(1, 300, 27'h4000000, 0, 3'd3, 5'b00000, 32'hFF7FFFFF, 5'h05));
      vecs.push_back(mk(0, 127, 27'h4000004, 0, 3'd0, 5'b00000, 32'h3F800000, 5'h01));
      vecs.push_back(mk(0, 127, 27'h4000004, 0, 3'd4, 5'b00000, 32'h3F800001, 5'h01));
      vecs.push_back(mk(0, 127, 27'h400000C, 0, 3'd0, 5'b00000, 32'h3F800002, 5'h01));
      vecs.push_back(mk(0,   1, 27'h3FFFFFE, 0, 3'd0, 5'b00000, 32'h00800000, 5'h03));
      vecs.push_back(mk(0, -100, 27'h4000000, 0, 3'd3, 5'b00000, 32'h00000001, 5'h03));
      vecs.push_back(mk(0, -100, 27'h4000000, 0, 3'd0, 5'b00000, 32'h00000000, 5'h03));
      vecs.push_back(mk(0, 127, 27'h2AAAAAA, 1, 3'd5, 5'b00000, 32'h3F2AAAAB, 5'h01));
      vecs.push_back(mk(0, 127, 27'h4000000, 0, 3'd0, 5'b10100, 32'h7FC00000, 5'h00));
      vecs.push_back(mk(0, 127, 27'h4000000, 0, 3'd0, 5'b00010, 32'h7F800000, 5'h00));
      vecs.push_back(mk(1, 127, 27'h4000000, 0, 3'd0, 5'b00001, 32'h80000000, 5'h00));
      vecs.push_back(mk(1, 127, 27'h4000000, 0, 3'd0, 5'b00011, 32'hFF800000, 5'h00));

      in_Rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
      apply_vec(vecs[0]);
      @(posedge in_Clk); #1;
      @(posedge in_Clk); #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_result", 64'(out_result), 64'(0));
      chk("rst_fflags", 64'(out_fflags), 64'(0));
      in_Rst = 1'b0;
      @(posedge in_Clk); #1;
      chk("rst_in_ready", 64'(out_in_ready), 64'(1));

      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(vecs[i]);
         in_valid = 1'b1;
         in_ready = 1'b1;
         #1;
         chk($sformatf("vec%0d_accept", i), 64'(out_in_ready), 64'(1));
         @(posedge in_Clk); #1;
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 8) begin
            @(posedge in_Clk); #1;
            lat++;
         end
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(1));
         chk($sformatf("vec%0d_result", i), {27'b0, out_fflags, out_result}, {27'b0, vecs[i].fl, vecs[i].res});
         @(posedge in_Clk); #1;
      end

      sent = 0; cyc = 0;
      while (sent < 400 && cyc < 5000) begin
         rand_inputs();
         in_valid = ($urandom_range(0, 9) < 7);
         in_ready = ($urandom_range(0, 9) < 7);
         step();
         if (acc_last) sent++;
         cyc++;
      end
      in_valid = 1'b0; in_ready = 1'b1; cyc = 0;
      while ((exp_q.size() != 0 || out_valid) && cyc < 20) begin
         step();
         cyc++;
      end
      chk("rand_sent", 64'(sent), 64'(400));
      chk("rand_drain", 64'(exp_q.size()), 64'(0));

      in_ready = 1'b0; idx = 0;
      for (int c = 0; c < 4; c++) begin
         apply_vec(vecs[idx]);
         in_valid = 1'b1;
         step();
         if (acc_last) idx++;
      end
      chk("bp_accepts", 64'(idx), 64'(2));
      chk("bp_in_ready", 64'(out_in_ready), 64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      hold_r = {out_fflags, out_result};
      step();
      chk("bp_hold", {27'b0, out_fflags, out_result}, 64'(hold_r));
      chk("bp_head", {27'b0, out_fflags, out_result}, 64'(exp_q[0]));
      in_ready = 1'b1; cyc = 0;
      while ((idx < 3 || exp_q.size() != 0) && cyc < 20) begin
         if (idx < 3) begin
            apply_vec(vecs[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (acc_last) idx++;
         cyc++;
      end
      chk("bp_all_out", 64'(idx == 3 && exp_q.size() == 0), 64'(1));

      in_ready = 1'b0;
      apply_vec(vecs[1]);
      in_valid = 1'b1;
      step(); step(); step();
      chk("rst_mid_pre", 64'(out_valid), 64'(1));
      in_Rst = 1'b1; in_valid = 1'b0;
      @(posedge in_Clk); #1;
      chk("rst_mid_valid", 64'(out_valid), 64'(0));
      chk("rst_mid_result", {27'b0, out_fflags, out_result}, 64'(0));
      chk("rst_mid_ready", 64'(out_in_ready), 64'(1));
      in_Rst = 1'b0;
      exp_q.delete();
      in_ready = 1'b1;
      apply_vec(vecs[5]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0; cyc = 0;
      while ((exp_q.size() != 0 || out_valid) && cyc < 20) begin
         step();
         cyc++;
      end
      chk("rst_after", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
